// File: rtl/dmem_sram_responder.sv
// Responder end of the CPU's sram-like data-memory interface: word-organised RAM
// with byte-lane writes, in-order completion queue and per-entry latency counters.
module dmem_sram_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned QDEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        hold,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned NW = $clog2(QDEPTH + 1);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [31:0]   r_mem  [DEPTH_WORDS];
    logic [31:0]   r_word [QDEPTH];
    logic          r_wr   [QDEPTH];
    logic [CW-1:0] r_cnt  [QDEPTH];
    logic [QW-1:0] r_head;
    logic [QW-1:0] r_tail;
    logic [NW-1:0] r_count;
    logic          r_data_ok;
    logic [31:0]   r_rdata;

    logic          w_accept;
    logic          w_pop;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [NW-1:0] w_count_nxt;
    logic [QW-1:0] w_head_nxt;
    logic [QW-1:0] w_tail_nxt;
    logic          w_unused;

    function automatic logic [QW-1:0] f_inc(input logic [QW-1:0] p);
        f_inc = (p == QW'(QDEPTH - 1)) ? '0 : p + QW'(1);
    endfunction

    // Upper address bits are ignored: the RAM wraps modulo its depth.
    assign w_idx        = data_addr[AW+1:2];
    assign w_unused     = &{1'b0, data_addr[31:AW+2]};
    assign data_addr_ok = (r_count < NW'(QDEPTH));
    assign data_data_ok = r_data_ok;
    assign data_rdata   = r_rdata;

    // Byte-lane enables from transfer size and low address bits
    always_comb begin
        w_be = 4'b1111;
        case (data_size)
            2'd0:    w_be = 4'(4'b0001 << data_addr[1:0]);
            2'd1:    w_be = data_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Queue bookkeeping: accept/pop decisions and next pointers/count
    always_comb begin
        w_accept    = data_req & data_addr_ok;
        w_pop       = (r_count != '0) & ~hold & (r_cnt[r_head] == '0);
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (w_pop) begin
            w_head_nxt = f_inc(r_head);
        end
        if (w_accept) begin
            w_tail_nxt = f_inc(r_tail);
        end
        case ({w_accept, w_pop})
            2'b10:   w_count_nxt = r_count + NW'(1);
            2'b01:   w_count_nxt = r_count - NW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // RAM and entry payload survive reset; reads capture the word at accept
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (data_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        r_mem[w_idx][8*b +: 8] <= data_wdata[8*b +: 8];
                    end
                end
            end
            r_word[r_tail] <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_data_ok <= 1'b0;
            r_rdata   <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                r_wr[i]  <= 1'b0;
                r_cnt[i] <= '0;
            end
        end else begin
            r_head    <= w_head_nxt;
            r_tail    <= w_tail_nxt;
            r_count   <= w_count_nxt;
            r_data_ok <= w_pop;
            if (w_pop) begin
                r_rdata <= r_wr[r_head] ? 32'h0 : r_word[r_head];
            end
            // Stale counters in free slots may tick too; the tail load overrides them
            for (int i = 0; i < int'(QDEPTH); i++) begin
                if (!hold && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - CW'(1);
                end
            end
            if (w_accept) begin
                r_wr[r_tail]  <= data_wr;
                r_cnt[r_tail] <= CW'(LATENCY - 1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Randomized and directed bench for dmem_sram_responder against a queue-of-deadlines
// reference model with a flat word-array memory.
module tb_dmem_sram_responder;

    localparam int unsigned DEPTH_WORDS = 1024;
    localparam int unsigned LATENCY     = 2;
    localparam int unsigned QDEPTH      = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic        hold = 1'b0;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    dmem_sram_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .LATENCY    (LATENCY),
        .QDEPTH     (QDEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .hold        (hold),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_dok    = 0;

    // Reference model: memory words, queue of (expected rdata, non-hold edges since accept)
    logic [31:0] m_mem [DEPTH_WORDS];
    logic [31:0] q_data [$];
    int          q_age  [$];
    logic        m_addr_ok = 1'b1;
    logic        m_data_ok = 1'b0;
    logic [31:0] m_rdata   = 32'h0;
    logic        m_acc     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Applies one rising edge to the model using the inputs the DUT also sees
    task automatic model_edge();
        int          idx;
        logic [31:0] mask;
        m_acc     = data_req && (q_data.size() < int'(QDEPTH));
        m_data_ok = 1'b0;
        if (!hold) begin
            foreach (q_age[i]) q_age[i] = q_age[i] + 1;
            if (q_data.size() > 0 && q_age[0] >= int'(LATENCY)) begin
                m_rdata = q_data.pop_front();
                void'(q_age.pop_front());
                m_data_ok = 1'b1;
            end
        end
        if (m_acc) begin
            idx = int'((data_addr >> 2) % DEPTH_WORDS);
            if (data_wr) begin
                if (data_size == 2'd0)      mask = 32'hFF << (8 * data_addr[1:0]);
                else if (data_size == 2'd1) mask = data_addr[1] ? 32'hFFFF0000 : 32'h0000FFFF;
                else                        mask = 32'hFFFFFFFF;
                m_mem[idx] = (m_mem[idx] & ~mask) | (data_wdata & mask);
                q_data.push_back(32'h0);
            end else begin
                q_data.push_back(m_mem[idx]);
            end
            q_age.push_back(0);
        end
        m_addr_ok = (q_data.size() < int'(QDEPTH));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (data_data_ok === 1'b1) n_dok++;
        chk("addr_ok", 32'(data_addr_ok), 32'(m_addr_ok));
        chk("data_ok", 32'(data_data_ok), 32'(m_data_ok));
        chk("rdata",   data_rdata,        m_rdata);
    endtask

    task automatic reset_dut();
        data_req = 1'b0;
        hold     = 1'b0;
        rst      = 1'b1;
        #1;
        q_data.delete();
        q_age.delete();
        m_addr_ok = 1'b1;
        m_data_ok = 1'b0;
        m_rdata   = 32'h0;
        chk("rst_addr_ok", 32'(data_addr_ok), 32'(m_addr_ok));
        chk("rst_data_ok", 32'(data_data_ok), 32'(m_data_ok));
        chk("rst_rdata",   data_rdata,        m_rdata);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one request and keeps it stable until accepted
    task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int budget = 0;
        data_req   = 1'b1;
        data_wr    = wr;
        data_size  = size;
        data_addr  = addr;
        data_wdata = wdata;
        do begin
            cycle();
            budget++;
        end while (!m_acc && budget < 50);
        if (!m_acc) chk("accept_timeout", 32'(budget), 32'd0);
        data_req = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (q_data.size() > 0 && budget < 100) begin
            cycle();
            budget++;
        end
        if (q_data.size() > 0) chk("drain_timeout", 32'(q_data.size()), 32'd0);
    endtask

    initial begin
        int dok0;
        #2;
        reset_dut();

        // Word write, then byte write into lane 1 and a word read-back
        issue(1'b1, 2'd2, 32'h0000_0010, 32'hDEADBEEF);
        drain();
        issue(1'b1, 2'd0, 32'h0000_0011, 32'h0000AA00);
        issue(1'b0, 2'd2, 32'h0000_0010, 32'h0);
        drain();
        chk("t2_rdata", data_rdata, 32'hDEADAAEF);

        // Initialise the 64-word window used by the random phase
        for (int i = 0; i < 64; i++) issue(1'b1, 2'd2, 32'(i * 4), $urandom);
        drain();

        // Four back-to-back reads: queue fills, four in-order pulses
        dok0 = n_dok;
        for (int i = 0; i < 4; i++) issue(1'b0, 2'd2, 32'(i * 4 + 32'h40), 32'h0);
        drain();
        chk("t3_pulses", 32'(n_dok - dok0), 32'd4);

        // Read immediately following a write to the same word
        issue(1'b1, 2'd2, 32'h0000_0020, 32'h12345678);
        issue(1'b0, 2'd2, 32'h0000_0020, 32'h0);
        drain();
        chk("t4_rdata", data_rdata, 32'h12345678);

        // Hold for five cycles with two reads outstanding
        issue(1'b0, 2'd2, 32'h0000_0050, 32'h0);
        issue(1'b0, 2'd2, 32'h0000_0054, 32'h0);
        hold = 1'b1;
        dok0 = n_dok;
        for (int i = 0; i < 5; i++) cycle();
        chk("t5_no_ok_in_hold", 32'(n_dok - dok0), 32'd0);
        hold = 1'b0;
        drain();
        chk("t5_rdata", data_rdata, m_mem[21]);

        // Reset with a write and a read outstanding; the write must persist
        issue(1'b1, 2'd2, 32'h0000_0030, 32'hCAFEF00D);
        issue(1'b0, 2'd2, 32'h0000_0044, 32'h0);
        reset_dut();
        cycle();
        issue(1'b0, 2'd2, 32'h0000_0030, 32'h0);
        drain();
        chk("t6_rdata", data_rdata, 32'hCAFEF00D);

        // Random traffic: sizes, lanes, wrapped upper address bits, random hold
        for (int c = 0; c < 1500; c++) begin
            if (!(data_req && !m_acc)) begin
                data_req   = ($urandom_range(0, 2) != 0);
                data_wr    = $urandom_range(0, 1) == 1;
                data_size  = 2'($urandom);
                data_addr  = {20'($urandom), 4'b0000, 6'($urandom), 2'($urandom)};
                data_wdata = $urandom;
            end
            hold = ($urandom_range(0, 4) == 0);
            cycle();
        end
        data_req = 1'b0;
        hold     = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
